// File: rtl/usr_cfg_ctrl.sv
// usr_cfg_ctrl: queues user register reads/writes and serialises them
// onto a single req/ack register bus with per-transaction timeout.
module usr_cfg_ctrl #(
    parameter int REG_ADDR_WIDTH = 32,
    parameter int REG_DATA_WIDTH = 32,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYC    = 255
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      usr_cfg_type,
    input  logic                      usr_wr_en,
    input  logic [REG_ADDR_WIDTH-1:0] usr_wr_addr,
    input  logic [REG_DATA_WIDTH-1:0] usr_wr_data,
    input  logic                      usr_rd_en,
    input  logic [REG_ADDR_WIDTH-1:0] usr_rd_addr,
    output logic                      usr_rd_vld,
    output logic [REG_DATA_WIDTH-1:0] usr_rd_data,
    output logic                      reg_req,
    output logic                      reg_sel,
    output logic                      reg_wr,
    output logic [REG_ADDR_WIDTH-1:0] reg_addr,
    output logic [REG_DATA_WIDTH-1:0] reg_wdata,
    input  logic                      reg_ack,
    input  logic [REG_DATA_WIDTH-1:0] reg_rdata,
    output logic                      busy,
    output logic                      err_overflow,
    output logic                      err_timeout
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_GAP
    } state_t;

    typedef struct packed {
        logic                      sel;
        logic                      wr;
        logic [REG_ADDR_WIDTH-1:0] addr;
        logic [REG_DATA_WIDTH-1:0] data;
    } cmd_t;

    cmd_t                      mem_q [FIFO_DEPTH];

    state_t                    state_q, state_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [PW-1:0]             wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]             rd_ptr_q, rd_ptr_d;
    logic [7:0]                tcnt_q, tcnt_d;
    logic                      req_q, req_d;
    logic                      sel_q, sel_d;
    logic                      wr_q, wr_d;
    logic [REG_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [REG_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                      rd_vld_q, rd_vld_d;
    logic [REG_DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                      ovf_q, ovf_d;
    logic                      to_q, to_d;

    logic [CW-1:0]             free;
    logic                      wr_ok;
    logic                      rd_ok;
    logic                      pop;
    logic [CW-1:0]             n_push;
    logic [PW-1:0]             rd_slot;
    cmd_t                      wr_cmd;
    cmd_t                      rd_cmd;
    cmd_t                      head;

    // Free slots are judged on pre-edge occupancy; a same-edge pop
    // does not make room for a push.
    always_comb begin
        free    = CW'(FIFO_DEPTH) - cnt_q;
        wr_ok   = usr_wr_en && (free != '0);
        rd_ok   = usr_rd_en && (free > {{(CW-1){1'b0}}, wr_ok});
        pop     = (state_q == S_IDLE) && (cnt_q != '0);
        n_push  = CW'(wr_ok) + CW'(rd_ok);
        rd_slot = wr_ptr_q + PW'(wr_ok);
        head    = mem_q[rd_ptr_q];

        wr_cmd.sel  = usr_cfg_type;
        wr_cmd.wr   = 1'b1;
        wr_cmd.addr = usr_wr_addr;
        wr_cmd.data = usr_wr_data;

        rd_cmd.sel  = usr_cfg_type;
        rd_cmd.wr   = 1'b0;
        rd_cmd.addr = usr_rd_addr;
        rd_cmd.data = '0;

        cnt_d    = cnt_q + n_push - CW'(pop);
        wr_ptr_d = wr_ptr_q + PW'(n_push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        ovf_d    = (usr_wr_en && !wr_ok) || (usr_rd_en && !rd_ok);
    end

    always_comb begin
        state_d   = state_q;
        tcnt_d    = tcnt_q;
        req_d     = req_q;
        sel_d     = sel_q;
        wr_d      = wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rd_vld_d  = 1'b0;
        rd_data_d = rd_data_q;
        to_d      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (pop) begin
                    sel_d   = head.sel;
                    wr_d    = head.wr;
                    addr_d  = head.addr;
                    wdata_d = head.data;
                    req_d   = 1'b1;
                    tcnt_d  = '0;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (reg_ack) begin
                    req_d   = 1'b0;
                    state_d = S_GAP;
                    if (!wr_q) begin
                        rd_vld_d  = 1'b1;
                        rd_data_d = reg_rdata;
                    end
                end else if (tcnt_q == 8'(TIMEOUT_CYC - 1)) begin
                    req_d   = 1'b0;
                    to_d    = 1'b1;
                    state_d = S_GAP;
                    if (!wr_q) begin
                        rd_vld_d  = 1'b1;
                        rd_data_d = '1;
                    end
                end else begin
                    tcnt_d = tcnt_q + 8'd1;
                end
            end
            S_GAP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Queue storage carries no reset; only the pointers define contents.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[wr_ptr_q] <= wr_cmd;
        end
        if (rd_ok) begin
            mem_q[rd_slot] <= rd_cmd;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            tcnt_q    <= '0;
            req_q     <= 1'b0;
            sel_q     <= 1'b0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rd_vld_q  <= 1'b0;
            rd_data_q <= '0;
            ovf_q     <= 1'b0;
            to_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            tcnt_q    <= tcnt_d;
            req_q     <= req_d;
            sel_q     <= sel_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rd_vld_q  <= rd_vld_d;
            rd_data_q <= rd_data_d;
            ovf_q     <= ovf_d;
            to_q      <= to_d;
        end
    end

    assign reg_req      = req_q;
    assign reg_sel      = sel_q;
    assign reg_wr       = wr_q;
    assign reg_addr     = addr_q;
    assign reg_wdata    = wdata_q;
    assign usr_rd_vld   = rd_vld_q;
    assign usr_rd_data  = rd_data_q;
    assign err_overflow = ovf_q;
    assign err_timeout  = to_q;
    assign busy         = (state_q != S_IDLE) || (cnt_q != '0);

endmodule

// File: tb/tb_usr_cfg_ctrl.sv
// Bench for usr_cfg_ctrl: random traffic, queue-level reference model,
// scoreboard monitor stamped with expected edge numbers.
module tb_usr_cfg_ctrl;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int DEP = 4;
    localparam int TO  = 12;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          usr_cfg_type = 1'b0;
    logic          usr_wr_en = 1'b0;
    logic [AW-1:0] usr_wr_addr = '0;
    logic [DW-1:0] usr_wr_data = '0;
    logic          usr_rd_en = 1'b0;
    logic [AW-1:0] usr_rd_addr = '0;
    logic          usr_rd_vld;
    logic [DW-1:0] usr_rd_data;
    logic          reg_req;
    logic          reg_sel;
    logic          reg_wr;
    logic [AW-1:0] reg_addr;
    logic [DW-1:0] reg_wdata;
    logic          reg_ack = 1'b0;
    logic [DW-1:0] reg_rdata = '0;
    logic          busy;
    logic          err_overflow;
    logic          err_timeout;

    usr_cfg_ctrl #(
        .REG_ADDR_WIDTH(AW),
        .REG_DATA_WIDTH(DW),
        .FIFO_DEPTH    (DEP),
        .TIMEOUT_CYC   (TO)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .usr_cfg_type(usr_cfg_type),
        .usr_wr_en   (usr_wr_en),
        .usr_wr_addr (usr_wr_addr),
        .usr_wr_data (usr_wr_data),
        .usr_rd_en   (usr_rd_en),
        .usr_rd_addr (usr_rd_addr),
        .usr_rd_vld  (usr_rd_vld),
        .usr_rd_data (usr_rd_data),
        .reg_req     (reg_req),
        .reg_sel     (reg_sel),
        .reg_wr      (reg_wr),
        .reg_addr    (reg_addr),
        .reg_wdata   (reg_wdata),
        .reg_ack     (reg_ack),
        .reg_rdata   (reg_rdata),
        .busy        (busy),
        .err_overflow(err_overflow),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            sel;
        bit            wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } cmd_s;

    typedef struct {
        cmd_s cmd;
        int   t;
    } req_e;

    typedef struct {
        logic [DW-1:0] d;
        int            t;
    } rd_e;

    typedef struct {
        int            lat;
        logic [DW-1:0] rd;
    } ack_e;

    cmd_s mq[$];
    req_e exp_req[$];
    rd_e  exp_rd[$];
    int   exp_ovf[$];
    int   exp_to[$];
    ack_e ackq[$];
    bit   busy_at[int];

    int            cyc = 0;
    int            idle_at = 0;
    int            vectors = 0;
    int            errors = 0;
    bit            chk_en = 0;
    bit            resp_en = 0;
    bit            model_en = 0;
    bit            req_prev = 0;
    cmd_s          cur;
    logic [DW-1:0] last_rd = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h exp %h (edge %0d)", name, got, exp, cyc);
        end
    endtask

    // Drive one cycle of user inputs and advance the reference model
    // to the edge that will sample them.
    task automatic step(input bit we, input bit re, input bit typ,
                        input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        input logic [AW-1:0] ra);
        int   t;
        int   free;
        int   e;
        bit   pop;
        bit   wok;
        bit   rok;
        bit   acked;
        cmd_s c;
        ack_e a;
        @(negedge clk);
        usr_wr_en    = we;
        usr_rd_en    = re;
        usr_cfg_type = typ;
        usr_wr_addr  = wa;
        usr_wr_data  = wd;
        usr_rd_addr  = ra;
        if (model_en) begin
            t    = cyc + 1;
            free = DEP - mq.size();
            pop  = (t >= idle_at) && (mq.size() > 0);
            if (pop) begin
                c = mq.pop_front();
                exp_req.push_back('{cmd: c, t: t});
                case ($urandom_range(0, 9))
                    0:       a.lat = 0;
                    1:       a.lat = TO;
                    2:       a.lat = TO + 1;
                    default: a.lat = $urandom_range(1, 5);
                endcase
                a.rd = $urandom;
                ackq.push_back(a);
                acked = (a.lat != 0) && (a.lat <= TO);
                e = acked ? t + a.lat : t + TO;
                if (!acked) exp_to.push_back(e);
                if (!c.wr) exp_rd.push_back('{d: acked ? a.rd : '1, t: e});
                idle_at = e + 2;
            end
            wok = we && (free >= 1);
            rok = re && (free >= (wok ? 2 : 1));
            if (wok) mq.push_back('{sel: typ, wr: 1'b1, addr: wa, data: wd});
            if (rok) mq.push_back('{sel: typ, wr: 1'b0, addr: ra, data: '0});
            if ((we && !wok) || (re && !rok)) exp_ovf.push_back(t);
            busy_at[t] = (mq.size() > 0) || (t < idle_at - 1);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, '0, '0, '0);
    endtask

    // Register-bus responder: acks each request after the latency the
    // model chose for it (0 = never).
    initial begin : responder
        bit   prev;
        ack_e a;
        prev = 0;
        forever begin
            @(negedge clk);
            if (resp_en && reg_req && !prev) begin
                if (ackq.size() == 0) begin
                    errors++;
                    $display("FAIL resp_unexpected_req at edge %0d", cyc);
                end else begin
                    a = ackq.pop_front();
                    if (a.lat > 0) begin
                        repeat (a.lat - 1) @(negedge clk);
                        reg_ack   = 1'b1;
                        reg_rdata = a.rd;
                        @(negedge clk);
                        reg_ack   = 1'b0;
                        reg_rdata = ~a.rd;
                    end
                end
            end
            prev = reg_req;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            if (reg_req && !req_prev) begin
                if (exp_req.size() == 0) begin
                    chk("req_unexpected", 1, 0);
                end else begin
                    cur = exp_req[0].cmd;
                    chk("req_edge", 64'(cyc), 64'(exp_req[0].t));
                    void'(exp_req.pop_front());
                end
            end
            if (reg_req) begin
                chk("req_fields", {reg_sel, reg_wr, reg_addr, reg_wdata[29:0]},
                    {cur.sel, cur.wr, cur.addr, cur.data[29:0]});
            end
            if (usr_rd_vld) begin
                if (exp_rd.size() == 0) begin
                    chk("rd_vld_unexpected", 1, 0);
                end else begin
                    chk("rd_data", 64'(usr_rd_data), 64'(exp_rd[0].d));
                    chk("rd_edge", 64'(cyc), 64'(exp_rd[0].t));
                    last_rd = exp_rd[0].d;
                    void'(exp_rd.pop_front());
                end
            end else begin
                chk("rd_hold", 64'(usr_rd_data), 64'(last_rd));
            end
            if (err_overflow) begin
                if (exp_ovf.size() == 0) chk("ovf_unexpected", 1, 0);
                else chk("ovf_edge", 64'(cyc), 64'(exp_ovf.pop_front()));
            end
            if (err_timeout) begin
                if (exp_to.size() == 0) chk("to_unexpected", 1, 0);
                else chk("to_edge", 64'(cyc), 64'(exp_to.pop_front()));
            end
            if (exp_req.size() > 0 && exp_req[0].t < cyc) begin
                chk("req_missed", 0, 1);
                void'(exp_req.pop_front());
            end
            if (exp_rd.size() > 0 && exp_rd[0].t < cyc) begin
                chk("rd_missed", 0, 1);
                void'(exp_rd.pop_front());
            end
            if (exp_ovf.size() > 0 && exp_ovf[0] < cyc) begin
                chk("ovf_missed", 0, 1);
                void'(exp_ovf.pop_front());
            end
            if (exp_to.size() > 0 && exp_to[0] < cyc) begin
                chk("to_missed", 0, 1);
                void'(exp_to.pop_front());
            end
            if (busy_at.exists(cyc)) begin
                chk("busy", 64'(busy), 64'(busy_at[cyc]));
                busy_at.delete(cyc);
            end
        end
        req_prev = reg_req;
    end

    initial begin : main
        int n;
        #1;
        chk("reset_outputs",
            {reg_req, reg_sel, reg_wr, usr_rd_vld, err_overflow,
             err_timeout, busy, reg_addr[15:0], reg_wdata[15:0],
             usr_rd_data[15:0]}, '0);
        repeat (3) @(negedge clk);
        rstn     = 1'b1;
        chk_en   = 1;
        resp_en  = 1;
        model_en = 1;

        step(1, 0, 1, 32'h10, 32'hA5, '0);
        idle(20);
        step(0, 1, 0, '0, '0, 32'h04);
        idle(20);
        step(1, 1, 0, 32'h08, 32'h5A5A, 32'h0C);
        idle(40);
        for (int i = 0; i < 6; i++) step(1, 0, 0, 32'(32'h40 + i), 32'(i), '0);
        idle(120);

        for (int i = 0; i < 1500; i++) begin
            step(1'($urandom_range(0, 99) < 35), 1'($urandom_range(0, 99) < 25),
                 1'($urandom), $urandom, $urandom, $urandom);
        end

        n = 0;
        while ((mq.size() > 0 || cyc < idle_at + 2) && n < 1000) begin
            idle(1);
            n++;
        end
        idle(4);
        chk("drain_req", 64'(exp_req.size()), 0);
        chk("drain_rd", 64'(exp_rd.size()), 0);
        chk("drain_ovf", 64'(exp_ovf.size()), 0);
        chk("drain_to", 64'(exp_to.size()), 0);
        chk("drain_ack", 64'(ackq.size()), 0);

        chk_en   = 0;
        resp_en  = 0;
        model_en = 0;
        for (int i = 0; i < 3; i++) step(1, 0, 1, 32'(32'h80 + i), 32'hBEEF, '0);
        idle(1);
        n = 0;
        while (!reg_req && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("rst_req_seen", 64'(reg_req), 1);
        rstn = 1'b0;
        #1;
        chk("rst_async", {reg_req, busy, usr_rd_vld, err_timeout}, '0);
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 3 * TO; i++) begin
            @(negedge clk);
            chk("post_rst_quiet",
                {reg_req, busy, usr_rd_vld, err_timeout, err_overflow}, '0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
